// File: rtl/hub75_panel_rx.sv
// hub75_panel_rx: HUB75 panel receiver. It samples the shift/latch/blank/data pins,
// rebuilds each latched line pair and drains it as pixel writes (top half first, then
// bottom half). It also reports per-period on-time and flags protocol violations.
`timescale 1ns/1ps
module hub75_panel_rx #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 4,
  parameter int ONTIME_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sclk,
  input  logic                      latch,
  input  logic                      blank,
  input  logic [2:0]                din_top,
  input  logic [2:0]                din_btm,
  input  logic [ROW_BITS-1:0]       row_sel,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ROW_BITS:0]         wr_row,
  output logic [$clog2(COLS)-1:0]   wr_col,
  output logic [2:0]                wr_rgb,
  output logic [ONTIME_W-1:0]       ontime,
  output logic                      ontime_valid,
  output logic                      err_count,
  output logic                      err_unblanked,
  output logic                      err_overlap
);

  localparam int COL_W = $clog2(COLS);
  localparam int CNT_W = $clog2(COLS + 2);
  localparam logic [CNT_W-1:0]    CNT_SAT    = CNT_W'(COLS + 1);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(COLS);
  localparam logic [COL_W-1:0]    LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ONTIME_W-1:0] ONTIME_MAX = {ONTIME_W{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_TOP, ST_BTM} state_t;

  state_t               state_reg;
  logic                 sclk_q_reg;
  logic                 latch_q_reg;
  logic [3*COLS-1:0]    sh_top_reg;
  logic [3*COLS-1:0]    sh_btm_reg;
  logic [3*COLS-1:0]    sh_top_next;
  logic [3*COLS-1:0]    sh_btm_next;
  logic [3*COLS-1:0]    hold_top_reg;
  logic [3*COLS-1:0]    hold_btm_reg;
  logic [ROW_BITS-1:0]  row_reg;
  logic [CNT_W-1:0]     shift_cnt_reg;
  logic [CNT_W-1:0]     shift_cnt_next;
  logic [ONTIME_W-1:0]  ontime_cnt_reg;
  logic                 sclk_rise;
  logic                 latch_rise;
  logic [2:0]           top_col [COLS];
  logic [2:0]           btm_col [COLS];

  // Pins are used unregistered; edges are relative to the previous cycle's sample.
  assign sclk_rise  = sclk & ~sclk_q_reg;
  assign latch_rise = latch & ~latch_q_reg;

  // Post-shift view: a shift coinciding with a latch is part of the committed line.
  always_comb begin
    sh_top_next    = sh_top_reg;
    sh_btm_next    = sh_btm_reg;
    shift_cnt_next = shift_cnt_reg;
    if (sclk_rise) begin
      sh_top_next = {din_top, sh_top_reg[3*COLS-1:3]};
      sh_btm_next = {din_btm, sh_btm_reg[3*COLS-1:3]};
      if (shift_cnt_reg != CNT_SAT) begin
        shift_cnt_next = shift_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Edge history and the two shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q_reg  <= 1'b1;
      latch_q_reg <= 1'b1;
      sh_top_reg  <= '0;
      sh_btm_reg  <= '0;
    end else begin
      sclk_q_reg  <= sclk;
      latch_q_reg <= latch;
      sh_top_reg  <= sh_top_next;
      sh_btm_reg  <= sh_btm_next;
    end
  end

  // Shift counting, on-time accounting and the latch-time status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt_reg  <= '0;
      ontime_cnt_reg <= '0;
      ontime         <= '0;
      ontime_valid   <= 1'b0;
      err_count      <= 1'b0;
      err_unblanked  <= 1'b0;
    end else begin
      ontime_valid  <= latch_rise;
      err_count     <= latch_rise && (shift_cnt_next != CNT_FULL);
      err_unblanked <= latch_rise && !blank;
      if (latch_rise) begin
        shift_cnt_reg  <= '0;
        ontime         <= ontime_cnt_reg;
        // A blank-low cycle on the latch edge already belongs to the new period.
        ontime_cnt_reg <= blank ? '0 : ONTIME_W'(1);
      end else begin
        shift_cnt_reg <= shift_cnt_next;
        if (!blank && ontime_cnt_reg != ONTIME_MAX) begin
          ontime_cnt_reg <= ontime_cnt_reg + ONTIME_W'(1);
        end
      end
    end
  end

  // Drain FSM: commit on latch when idle, then walk top half and bottom half.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wr_valid     <= 1'b0;
      wr_row       <= '0;
      wr_col       <= '0;
      row_reg      <= '0;
      hold_top_reg <= '0;
      hold_btm_reg <= '0;
      err_overlap  <= 1'b0;
    end else begin
      err_overlap <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (latch_rise) begin
            hold_top_reg <= sh_top_next;
            hold_btm_reg <= sh_btm_next;
            row_reg      <= row_sel;
            wr_row       <= {1'b0, row_sel};
            wr_col       <= '0;
            wr_valid     <= 1'b1;
            state_reg    <= ST_TOP;
          end
        end
        ST_TOP: begin
          err_overlap <= latch_rise;
          if (wr_ready) begin
            if (wr_col == LAST_COL) begin
              wr_col    <= '0;
              wr_row    <= {1'b1, row_reg};
              state_reg <= ST_BTM;
            end else begin
              wr_col <= wr_col + COL_W'(1);
            end
          end
        end
        ST_BTM: begin
          err_overlap <= latch_rise;
          if (wr_ready) begin
            if (wr_col == LAST_COL) begin
              wr_col    <= '0;
              wr_row    <= '0;
              wr_valid  <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              wr_col <= wr_col + COL_W'(1);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          wr_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Column view of the held line for the output pixel mux.
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_cols
      assign top_col[gi] = hold_top_reg[3*gi +: 3];
      assign btm_col[gi] = hold_btm_reg[3*gi +: 3];
    end
  endgenerate

  assign wr_rgb = !wr_valid ? 3'b000 :
                  (state_reg == ST_BTM) ? btm_col[wr_col] : top_col[wr_col];

endmodule
